mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 single-bit mux datapath (inputs in0..in3, selects s1/s0) between four requesters.
- Requester k drives mux input k. The arbiter grants one requester at a time and drives s1/s0 so the mux output carries the granted input.
- Sits directly in front of mux4to1. Its s1/s0 outputs connect straight to the mux select pins.

---
 rtl/mux4_rr_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter that shares one 4:1 single-bit mux between four
// requesters. Requester k drives mux input k. The registered s1/s0 outputs
// connect straight to the mux4to1 select pins.
//
// Optional feature macro: GRANT_TIMEOUT_EN
//   defined   -> an owner that has held the mux for HOLD_MAX cycles is
//                preempted when another requester is waiting.
//   undefined -> an owner keeps the mux for as long as it requests it.
//
// state | meaning
// IDLE  | no grant active; s1/s0 keep the last owner's index
// GRANT | requester {s1,s0} owns the mux

module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       valid,
  output logic [1:0] ptr
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  // Reject parameter sets the hold counter cannot represent.
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("mux4_rr_arbiter: HOLD_MAX must be in 1..255");
  end
  if ((64'd1 << CW) <= 64'(HOLD_MAX)) begin : g_bad_cw
    $error("mux4_rr_arbiter: CW too narrow for HOLD_MAX");
  end

  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          valid_q, valid_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]    owner;
  logic [3:0]    owner_oh;
  logic [3:0]    others;
  logic [3:0]    search_req;
  logic          win_found;
  logic [1:0]    win;
  logic          preempt;
  logic          owner_holds;
  logic          new_grant;
  logic          drop_grant;

  // First set bit of r searching upward from start, wrapping mod 4.
  // Iterating from the farthest offset down lets the nearest hit win.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // The owner index is the registered select value; it is only meaningful in GRANT.
  assign owner    = sel_q;
  assign owner_oh = 4'b0001 << owner;
  assign others   = req & ~owner_oh;

`ifdef GRANT_TIMEOUT_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  // Counter at or past its last allowed value: hand over if anyone else waits.
  // ">=" covers an owner that ran alone past the limit and is later joined.
  assign preempt = (state_q == GRANT) && (cnt_q >= HOLD_LAST) && (|others);
`else
  assign preempt = 1'b0;
`endif

  assign owner_holds = (state_q == GRANT) && (|(req & owner_oh)) && !preempt;

  // In GRANT the owner is excluded: it has either released or is being preempted.
  assign search_req = (state_q == IDLE) ? req : others;
  assign {win_found, win} = rr_pick(search_req, ptr_q);

  assign new_grant  = !owner_holds && win_found;
  assign drop_grant = (state_q == GRANT) && !owner_holds && !win_found;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (drop_grant) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered grant, select, pointer and hold counter.
  always_comb begin
    gnt_d = gnt_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (new_grant) begin
      gnt_d = 4'b0001 << win;
      sel_d = win;
      ptr_d = win + 2'd1;
      cnt_d = '0;
    end else if (owner_holds) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (drop_grant) begin
      gnt_d = 4'b0000;
      cnt_d = '0;
    end
  end

  assign valid_d = |gnt_d;

  // Output and bookkeeping registers; selects move only together with gnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      valid_q <= 1'b0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign valid = valid_q;
  assign ptr   = ptr_q;

`ifndef SYNTHESIS
  // Grant is one-hot or empty, and valid mirrors it.
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_valid_or:    assert property (@(posedge clk) disable iff (rst) valid_q == (|gnt_q));
  // While granted, the selects always point at the owner.
  a_sel_owner:   assert property (@(posedge clk) disable iff (rst)
                                  valid_q |-> (gnt_q == (4'b0001 << sel_q)));
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: a vector table for the single-cycle
// behaviour plus hand-written sequences for async reset, mux tracking and
// the hold/timeout behaviour (both builds of GRANT_TIMEOUT_EN).

module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       valid;
  logic [1:0] ptr;

  logic [3:0] in_bus;
  logic       mux_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [1:0] ptr;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  mux4_rr_arbiter #(
    .HOLD_MAX(4),
    .CW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .gnt(gnt),
    .s1(s1),
    .s0(s0),
    .valid(valid),
    .ptr(ptr)
  );

  // Behavioural mux4to1 fed by the arbiter selects.
  assign mux_out = in_bus[{s1, s0}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] g,
                              input logic [1:0] s, input logic v, input logic [1:0] p);
    vec_t t;
    t.rst = r; t.req = q; t.gnt = g; t.sel = s; t.valid = v; t.ptr = p;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx, input logic [3:0] eg,
                       input logic [1:0] es, input logic ev, input logic [1:0] ep);
    checks++;
    if (gnt !== eg || {s1, s0} !== es || valid !== ev || ptr !== ep) begin
      errors++;
      $display("FAIL %s[%0d] got gnt=%b sel=%b valid=%b ptr=%0d want gnt=%b sel=%b valid=%b ptr=%0d",
               tag, idx, gnt, {s1, s0}, valid, ptr, eg, es, ev, ep);
    end
  endtask

  task automatic check_mux(input int idx, input logic exp);
    checks++;
    if (mux_out !== exp) begin
      errors++;
      $display("FAIL mux_out[%0d] got %b want %b (sel=%b in=%b)", idx, mux_out, exp, {s1, s0}, in_bus);
    end
  endtask

  initial begin
    logic [2:0] pat;
    logic       p;
    logic       own0;
    logic [1:0] tsel;
    logic [1:0] tptr;
    logic [3:0] tgnt;

    rst    = 1'b1;
    req    = 4'b0000;
    in_bus = 4'b0000;

    //             rst  req      gnt      sel    v     ptr
    vecs[0]  = mk(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 2'd0); // reset state
    vecs[1]  = mk(1'b0, 4'b0001, 4'b0001, 2'b00, 1'b1, 2'd1); // single requester
    vecs[2]  = mk(1'b0, 4'b0001, 4'b0001, 2'b00, 1'b1, 2'd1);
    vecs[3]  = mk(1'b0, 4'b0001, 4'b0001, 2'b00, 1'b1, 2'd1);
    vecs[4]  = mk(1'b0, 4'b0001, 4'b0001, 2'b00, 1'b1, 2'd1);
    vecs[5]  = mk(1'b0, 4'b0001, 4'b0001, 2'b00, 1'b1, 2'd1);
    vecs[6]  = mk(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 2'd1); // release -> IDLE, sel held
    vecs[7]  = mk(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 2'd0); // reset again
    vecs[8]  = mk(1'b0, 4'b1111, 4'b0001, 2'b00, 1'b1, 2'd1); // rotation: 0
    vecs[9]  = mk(1'b0, 4'b1111, 4'b0001, 2'b00, 1'b1, 2'd1);
    vecs[10] = mk(1'b0, 4'b1110, 4'b0010, 2'b01, 1'b1, 2'd2); // 0 drops -> 1
    vecs[11] = mk(1'b0, 4'b1111, 4'b0010, 2'b01, 1'b1, 2'd2); // 0 re-raises, waits
    vecs[12] = mk(1'b0, 4'b1101, 4'b0100, 2'b10, 1'b1, 2'd3); // 1 drops -> 2
    vecs[13] = mk(1'b0, 4'b1111, 4'b0100, 2'b10, 1'b1, 2'd3);
    vecs[14] = mk(1'b0, 4'b1011, 4'b1000, 2'b11, 1'b1, 2'd0); // 2 drops -> 3
    vecs[15] = mk(1'b0, 4'b1111, 4'b1000, 2'b11, 1'b1, 2'd0);
    vecs[16] = mk(1'b0, 4'b0111, 4'b0001, 2'b00, 1'b1, 2'd1); // 3 drops -> 0 (wrap)
    vecs[17] = mk(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 2'd1);
    vecs[18] = mk(1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1, 2'd3); // sets ptr=3
    vecs[19] = mk(1'b0, 4'b0000, 4'b0000, 2'b10, 1'b0, 2'd3); // idle, sel stays 10
    vecs[20] = mk(1'b0, 4'b0011, 4'b0001, 2'b00, 1'b1, 2'd1); // ptr=3: 0 beats 1
    vecs[21] = mk(1'b0, 4'b0010, 4'b0010, 2'b01, 1'b1, 2'd2); // handover to 1
    vecs[22] = mk(1'b0, 4'b1001, 4'b1000, 2'b11, 1'b1, 2'd0); // 1 drops, 3 before 0
    vecs[23] = mk(1'b0, 4'b0000, 4'b0000, 2'b11, 1'b0, 2'd0); // idle, sel stays 11

    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      step();
      check("vec", i, vecs[i].gnt, vecs[i].sel, vecs[i].valid, vecs[i].ptr);
    end

    // Mux output follows in0 while requester 0 owns it, and after release.
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
    req = 4'b0001;
    step();
    check("mux_grant", 0, 4'b0001, 2'b00, 1'b1, 2'd1);
    pat = 3'b101;
    for (int k = 0; k < 3; k++) begin
      p = pat[k];
      in_bus = {~p, ~p, ~p, p};
      #1;
      check_mux(k, p);
      step();
    end
    req = 4'b0000;
    step();
    check("mux_idle", 0, 4'b0000, 2'b00, 1'b0, 2'd1);
    for (int k = 0; k < 2; k++) begin
      p = (k == 0);
      in_bus = {~p, ~p, ~p, p};
      #1;
      check_mux(3 + k, p);
    end

    // Async reset mid-grant with owner 2, no clock edge needed.
    req = 4'b0100;
    step();
    check("pre_reset", 0, 4'b0100, 2'b10, 1'b1, 2'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 0, 4'b0000, 2'b00, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0100;
    step();
    check("post_rst", 0, 4'b0100, 2'b10, 1'b1, 2'd3);

    // Hold / timeout behaviour with HOLD_MAX=4.
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
    req = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      step();
`ifdef GRANT_TIMEOUT_EN
      own0 = (((i / 4) % 2) == 0);
`else
      own0 = 1'b1;
`endif
      tgnt = own0 ? 4'b0001 : 4'b0010;
      tsel = own0 ? 2'b00 : 2'b01;
      tptr = own0 ? 2'd1 : 2'd2;
      check("hold_pair", i, tgnt, tsel, 1'b1, tptr);
    end
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_alone", i, 4'b0001, 2'b00, 1'b1, 2'd1);
    end
    req = 4'b0011;
    step();
`ifdef GRANT_TIMEOUT_EN
    check("late_rival", 0, 4'b0010, 2'b01, 1'b1, 2'd2);
`else
    check("late_rival", 0, 4'b0001, 2'b00, 1'b1, 2'd1);
`endif
    req = 4'b0000;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
